signal_timestamper: RTL
=======================

Name: signal_timestamper

Overview:
- Input-side counterpart of the signal generator: timestamps edges on an external event input against the local clock time (TC_Time bus).
- Removes the known input-path delay and buffers timestamps in a small FIFO.
- Results leave on a valid/ready stream with an interrupt pulse; the time-card register block reads them out.

Parameters:
- ClockPeriod_Gen, 20, SysClk period in ns; used for synchroniser delay compensation.
- InputDelay_Gen, 0, fixed board input delay in ns to subtract.
- InputPolarity_Gen, "true", "true" = rising edge is the event; "false" = falling edge.
- FifoDepth_Gen, 4, timestamp FIFO depth; power of two, 2..16.

Ports:
- SysClk_ClkIn  in  1  system clock; all logic on rising edge.
- SysRstN_RstIn  in  1  reset, synchronous, active-low.
- ClockTime_Second_DatIn  in  32  current time, seconds.
- ClockTime_Nanosecond_DatIn  in  32  current time, ns (0..999_999_999).
- ClockTime_TimeJump_DatIn  in  1  time discontinuity this cycle.
- ClockTime_ValIn  in  1  clock time valid.
- Enable_EnaIn  in  1  capture enable.
- SignalTimestamper_EvtIn  in  1  asynchronous event input.
- Timestamp_ValOut  out  1  FIFO head valid.
- Timestamp_RdyIn  in  1  consumer ready; pop when Val & Rdy.
- Timestamp_Second_DatOut  out  32  head timestamp, seconds.
- Timestamp_Nanosecond_DatOut  out  32  head timestamp, ns.
- Timestamp_Count_DatOut  out  32  head event sequence number.
- Overflow_DatOut  out  1  sticky: event lost because FIFO was full.
- OverflowClear_ValIn  in  1  clears Overflow_DatOut.
- Irq_EvtOut  out  1  one-cycle interrupt pulse.

Behaviour:
- Reset (SysRstN_RstIn low at a clock edge): all outputs 0, sync FFs 0, FIFO empty, event counter 0, overflow clear. Reset mid-operation discards FIFO contents.
- Sync chain: 2 FFs, then 1 previous-value register. Event detected at edge k+2 when the input is first sampled active at edge k.
- Polarity: the input is inverted before the sync chain when InputPolarity_Gen = "false".
- Acceptance: event accepted only if Enable_EnaIn=1, ClockTime_ValIn=1 and ClockTime_TimeJump_DatIn=0 in the detect cycle. Otherwise dropped silently; counter unchanged.
- Capture: on an accepted event, latch current Second/Nanosecond. Counter increments; the new value becomes this event's Count (first event = 1).
- Compensation (registered, 1 cycle): D = InputDelay_Gen + 3*ClockPeriod_Gen (+ cable delay, see below). D < 1e9 is guaranteed.
  - If ns >= D: ns_out = ns - D, sec_out = sec.
  - Else: ns_out = ns + 1_000_000_000 - D, sec_out = sec - 1. Use 32-bit unsigned arithmetic; second 0 wraps to 0xFFFFFFFF.
- FIFO write: 1 cycle after compensation. Timestamp_ValOut rises at edge k+4. FIFO is first-word fall-through and outputs are registered.
- Full FIFO: the event is dropped, Overflow_DatOut is set and the counter still increments, so consumers see the gap.
- Push and pop in the same cycle when full: both happen; no overflow.
- Overflow flag: OverflowClear_ValIn clears it. If clear and set occur in the same cycle, set wins.
- Irq_EvtOut: 1-cycle pulse on each FIFO write into an empty FIFO.
- Data outputs hold steady while Val=1 and Rdy=0.
- Counter wraps 0xFFFFFFFF -> 0.
- Events closer than 2 cycles apart cannot be resolved; this is a documented limit.

Optional Feature:
- SIGNAL_TIMESTAMPER_CABLE_DELAY_EN
  - Defined: adds port CableDelay_DatIn (in, 16, ns). Sampled at capture and added to D before the subtraction; the wrap rule is unchanged.
  - Undefined: the port is absent and the cable term is 0.

Decomposition:
- Shared package signal_timestamper_pkg:
  - NS_PER_SEC = 1_000_000_000 and SYNC_STAGES = 3.
  - Timestamp record typedef: second, nanosecond, count.
  - Function computing compensated time with borrow.
- One sub-module, signal_timestamper_fifo: synchronous FWFT FIFO of the record, with full/empty and simultaneous push/pop support.

Test Plan:
- ClockPeriod 20, InputDelay 0; rising edge, detect-cycle time sec=10 ns=1000 -> Second=10, Nanosecond=940, Count=1; Val rises 4 cycles after first sample; Irq pulses once.
- Detect-cycle time sec=5 ns=30 (D=60) -> Second=4, Nanosecond=999_999_970.
- Five events, Rdy=0, depth 4 -> four entries with Counts 1..4; Overflow=1. Then OverflowClear plus a sixth event in the same cycle -> Overflow stays 1. Drain, next event -> Count=7.
- Event with TimeJump=1, then one with ClockTime_ValIn=0, then one with Enable_EnaIn=0 -> no FIFO write, no Irq; next valid event gets Count=1.
- Reset low for one cycle with 3 entries queued -> next edge: Val=0, Count=0, Overflow=0; next event -> Count=1.
- With SIGNAL_TIMESTAMPER_CABLE_DELAY_EN, CableDelay=100, ns=1000 -> Nanosecond=840.

Source files
------------

// File: rtl/signal_timestamper_pkg.sv
// Shared types and helpers for the event timestamper: timestamp record and
// delay compensation with a borrow into the seconds field.
package signal_timestamper_pkg;

  localparam int unsigned NS_PER_SEC  = 1_000_000_000;
  localparam int unsigned SYNC_STAGES = 3;

  typedef struct packed {
    logic [31:0] second;
    logic [31:0] nanosecond;
    logic [31:0] count;
  } timestamp_t;

  // Subtract delayNs from the timestamp; second 0 wraps to 0xFFFFFFFF on borrow.
  function automatic timestamp_t compensateTime(input timestamp_t ts, input logic [31:0] delayNs);
    timestamp_t result;
    result = ts;
    if (ts.nanosecond >= delayNs) begin
      result.nanosecond = ts.nanosecond - delayNs;
    end else begin
      result.nanosecond = ts.nanosecond + 32'(NS_PER_SEC) - delayNs;
      result.second     = ts.second - 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/signal_timestamper_fifo.sv
// First-word fall-through FIFO of timestamp records with registered head
// outputs; a push into a full FIFO is accepted only alongside a pop.
module signal_timestamper_fifo
  import signal_timestamper_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       push,
  input  timestamp_t pushData,
  input  logic       pop,
  output logic       headVal,
  output timestamp_t headData,
  output logic       full_c,
  output logic       empty_c
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  timestamp_t mem [Depth];
  logic [PtrW-1:0] rdPtr, wrPtr, nextRdPtr;
  logic [CntW-1:0] count, afterPop, nextCount;
  logic doPush, doPop;

  assign full_c  = (count == CntW'(Depth));
  assign empty_c = (count == '0);

  always_comb begin
    doPop     = pop & ~empty_c;
    doPush    = push & (~full_c | doPop);
    afterPop  = count - CntW'(doPop);
    nextCount = afterPop + CntW'(doPush);
    nextRdPtr = rdPtr + PtrW'(doPop);
  end

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= pushData;
    end
  end

  // Head register tracks the slot that will be at the read pointer after this edge.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      headVal  <= 1'b0;
      headData <= '0;
    end else begin
      rdPtr   <= nextRdPtr;
      wrPtr   <= wrPtr + PtrW'(doPush);
      count   <= nextCount;
      headVal <= (nextCount != '0);
      if (doPush && (afterPop == '0)) begin
        headData <= pushData;
      end else if (nextCount != '0) begin
        headData <= mem[nextRdPtr];
      end
    end
  end

endmodule

// File: rtl/signal_timestamper.sv
// Timestamps edges of an asynchronous event input against the local clock time.
// Optional SIGNAL_TIMESTAMPER_CABLE_DELAY_EN adds a per-capture cable delay input.
module signal_timestamper
  import signal_timestamper_pkg::*;
#(
  parameter int unsigned ClockPeriod_Gen   = 20,
  parameter int unsigned InputDelay_Gen    = 0,
  parameter string       InputPolarity_Gen = "true",
  parameter int unsigned FifoDepth_Gen     = 4
) (
  input  logic        SysClk_ClkIn,
  input  logic        SysRstN_RstIn,
  input  logic [31:0] ClockTime_Second_DatIn,
  input  logic [31:0] ClockTime_Nanosecond_DatIn,
  input  logic        ClockTime_TimeJump_DatIn,
  input  logic        ClockTime_ValIn,
  input  logic        Enable_EnaIn,
  input  logic        SignalTimestamper_EvtIn,
  output logic        Timestamp_ValOut,
  input  logic        Timestamp_RdyIn,
  output logic [31:0] Timestamp_Second_DatOut,
  output logic [31:0] Timestamp_Nanosecond_DatOut,
  output logic [31:0] Timestamp_Count_DatOut,
  output logic        Overflow_DatOut,
  input  logic        OverflowClear_ValIn,
`ifdef SIGNAL_TIMESTAMPER_CABLE_DELAY_EN
  input  logic [15:0] CableDelay_DatIn,
`endif
  output logic        Irq_EvtOut
);

  localparam bit          RisingEvent = (InputPolarity_Gen == "true");
  localparam logic [31:0] BaseDelay   = 32'(InputDelay_Gen + SYNC_STAGES * ClockPeriod_Gen);

  logic [1:0]  syncReg;
  logic        prevReg;
  logic        evtLevel_c, detect_c, accept_c;
  logic        pop_c, push_c, overflowSet_c, fifoFull_c, fifoEmpty_c;
  logic [31:0] eventCount, delay_c;
  logic        capValid, compValid;
  timestamp_t  capTs, compTs, headTs;

  assign evtLevel_c = RisingEvent ? SignalTimestamper_EvtIn : ~SignalTimestamper_EvtIn;
  assign detect_c   = syncReg[1] & ~prevReg;
  assign accept_c   = detect_c & Enable_EnaIn & ClockTime_ValIn & ~ClockTime_TimeJump_DatIn;

`ifdef SIGNAL_TIMESTAMPER_CABLE_DELAY_EN
  logic [15:0] capCable;

  always_ff @(posedge SysClk_ClkIn) begin
    if (!SysRstN_RstIn) begin
      capCable <= '0;
    end else if (accept_c) begin
      capCable <= CableDelay_DatIn;
    end
  end

  assign delay_c = BaseDelay + 32'(capCable);
`else
  assign delay_c = BaseDelay;
`endif

  assign pop_c         = Timestamp_ValOut & Timestamp_RdyIn;
  assign push_c        = compValid & (~fifoFull_c | pop_c);
  assign overflowSet_c = compValid & fifoFull_c & ~pop_c;

  // Sync chain, capture stage, compensation stage, overflow and interrupt.
  always_ff @(posedge SysClk_ClkIn) begin
    if (!SysRstN_RstIn) begin
      syncReg         <= '0;
      prevReg         <= 1'b0;
      eventCount      <= '0;
      capValid        <= 1'b0;
      capTs           <= '0;
      compValid       <= 1'b0;
      compTs          <= '0;
      Overflow_DatOut <= 1'b0;
      Irq_EvtOut      <= 1'b0;
    end else begin
      syncReg   <= {syncReg[0], evtLevel_c};
      prevReg   <= syncReg[1];
      capValid  <= accept_c;
      compValid <= capValid;
      if (accept_c) begin
        eventCount       <= eventCount + 32'd1;
        capTs.second     <= ClockTime_Second_DatIn;
        capTs.nanosecond <= ClockTime_Nanosecond_DatIn;
        capTs.count      <= eventCount + 32'd1;
      end
      if (capValid) begin
        compTs <= compensateTime(capTs, delay_c);
      end
      if (overflowSet_c) begin
        Overflow_DatOut <= 1'b1;
      end else if (OverflowClear_ValIn) begin
        Overflow_DatOut <= 1'b0;
      end
      Irq_EvtOut <= push_c & fifoEmpty_c;
    end
  end

  signal_timestamper_fifo #(
    .Depth(FifoDepth_Gen)
  ) u_fifo (
    .clk     (SysClk_ClkIn),
    .rstN    (SysRstN_RstIn),
    .push    (push_c),
    .pushData(compTs),
    .pop     (pop_c),
    .headVal (Timestamp_ValOut),
    .headData(headTs),
    .full_c  (fifoFull_c),
    .empty_c (fifoEmpty_c)
  );

  assign Timestamp_Second_DatOut     = headTs.second;
  assign Timestamp_Nanosecond_DatOut = headTs.nanosecond;
  assign Timestamp_Count_DatOut      = headTs.count;

endmodule
